// File: rtl/proc_ctrl_pkg.sv
// Shared constants for the processor control unit: opcodes, FSM states, bus select codes.
package proc_ctrl_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  // Bus select codes for the default 8-register datapath; use the functions for other RIDX.
  localparam int SEL_DIN = 8;
  localparam int SEL_G   = 9;

  function automatic int sel_din(input int ridx);
    return 2 ** ridx;
  endfunction

  function automatic int sel_g(input int ridx);
    return (2 ** ridx) + 1;
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_onehot_dec.sv
// Binary-to-one-hot decoder with enable; drives the register write enables.
module onehot_dec #(
  parameter int W = 3
) (
  input  logic             en,
  input  logic [W-1:0]     idx,
  output logic [2**W-1:0]  onehot
);

  localparam int N = 2 ** W;
  localparam logic [N-1:0] ONE = N'(1);

  assign onehot = en ? (ONE << idx) : '0;

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit datapath. Optional macro PROC_CTRL_SUB_EN
// enables the sub opcode; without it opcode 011 behaves as a NOP.
//
// state | meaning
// T0    | idle, waiting for run; latches instr into IR
// T1    | mv/mvi/NOP write+done, or add/sub: load A with Rx
// T2    | add/sub: load G with A +/- Ry
// T3    | add/sub: write G into Rx, done
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int RIDX = 3,
  parameter int SELW = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic [3+2*RIDX-1:0]    instr,
  output logic [2**RIDX-1:0]     rin,
  output logic                   a_en,
  output logic                   g_en,
  output logic                   alu_sub,
  output logic [SELW-1:0]        bus_sel,
  output logic                   done,
  output logic                   busy
);

  localparam int IW = 3 + 2 * RIDX;
  localparam logic [SELW-1:0] BUS_DIN = SELW'(sel_din(RIDX));
  localparam logic [SELW-1:0] BUS_G   = SELW'(sel_g(RIDX));

`ifdef PROC_CTRL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  state_t            state;
  logic [IW-1:0]     ir;
  logic [2:0]        op;
  logic [RIDX-1:0]   rx;
  logic [RIDX-1:0]   ry;
  logic              is_sub;
  logic              is_arith;
  logic              rin_en;

  assign op       = ir[IW-1 -: 3];
  assign rx       = ir[2*RIDX-1 -: RIDX];
  assign ry       = ir[RIDX-1:0];
  assign is_sub   = SUB_EN && (op == OP_SUB);
  assign is_arith = (op == OP_ADD) || is_sub;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: if (run) begin
          ir    <= instr;
          state <= T1;
        end
        T1:      state <= is_arith ? T2 : T0;
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  // Outputs depend only on registered state and IR, so reset clears them immediately.
  always_comb begin
    rin_en  = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    alu_sub = 1'b0;
    bus_sel = '0;
    done    = 1'b0;
    case (state)
      T1: begin
        if (op == OP_MV) begin
          bus_sel = SELW'(ry);
          rin_en  = 1'b1;
          done    = 1'b1;
        end else if (op == OP_MVI) begin
          bus_sel = BUS_DIN;
          rin_en  = 1'b1;
          done    = 1'b1;
        end else if (is_arith) begin
          bus_sel = SELW'(rx);
          a_en    = 1'b1;
        end else begin
          done    = 1'b1;
        end
      end
      T2: begin
        bus_sel = SELW'(ry);
        g_en    = 1'b1;
        alu_sub = is_sub;
      end
      T3: begin
        bus_sel = BUS_G;
        rin_en  = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != T0);

  onehot_dec #(.W(RIDX)) u_rin_dec (
    .en     (rin_en),
    .idx    (rx),
    .onehot (rin)
  );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm; expectations follow PROC_CTRL_SUB_EN if defined.
module tb_proc_ctrl_fsm;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [8:0]  instr;
  logic [7:0]  rin;
  logic        a_en;
  logic        g_en;
  logic        alu_sub;
  logic [3:0]  bus_sel;
  logic        done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  proc_ctrl_fsm #(.RIDX(3), .SELW(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .instr   (instr),
    .rin     (rin),
    .a_en    (a_en),
    .g_en    (g_en),
    .alu_sub (alu_sub),
    .bus_sel (bus_sel),
    .done    (done),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the full output set: {rin, a_en, g_en, alu_sub, bus_sel, done, busy}.
  task automatic check_all(input string tag, input logic [7:0] e_rin, input logic e_a,
                           input logic e_g, input logic e_sub, input logic [3:0] e_sel,
                           input logic e_done, input logic e_busy);
    check(tag, {rin, a_en, g_en, alu_sub, bus_sel, done, busy},
          {e_rin, e_a, e_g, e_sub, e_sel, e_done, e_busy});
  endtask

  // Present instr with run for one T0 cycle; returns at the negedge inside T1.
  task automatic issue(input logic [8:0] ins);
    @(negedge clock);
    run   = 1'b1;
    instr = ins;
    @(negedge clock);
    run   = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    instr  = '0;
    #2;
    check_all("reset_outputs", 8'h00, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // mvi R2
    issue(9'b001_010_000);
    check_all("mvi_t1", 8'h04, 0, 0, 0, 4'd8, 1, 1);
    @(negedge clock);
    check_all("mvi_idle", 8'h00, 0, 0, 0, 4'd0, 0, 0);

    // mv R5,R2
    issue(9'b000_101_010);
    check_all("mv_t1", 8'h20, 0, 0, 0, 4'd2, 1, 1);
    @(negedge clock);
    check("mv_busy_after", busy, 1'b0);

    // add R1,R3 with a stray run pulse in T2
    issue(9'b010_001_011);
    check_all("add_t1", 8'h00, 1, 0, 0, 4'd1, 0, 1);
    @(negedge clock);
    check_all("add_t2", 8'h00, 0, 1, 0, 4'd3, 0, 1);
    run   = 1'b1;
    instr = 9'b001_111_000;
    @(negedge clock);
    run   = 1'b0;
    check_all("add_t3", 8'h02, 0, 0, 0, 4'd9, 1, 1);
    @(negedge clock);
    check_all("add_run_ignored", 8'h00, 0, 0, 0, 4'd0, 0, 0);

    // sub R0,R0
    issue(9'b011_000_000);
`ifdef PROC_CTRL_SUB_EN
    check_all("sub_t1", 8'h00, 1, 0, 0, 4'd0, 0, 1);
    @(negedge clock);
    check_all("sub_t2", 8'h00, 0, 1, 1, 4'd0, 0, 1);
    @(negedge clock);
    check_all("sub_t3", 8'h01, 0, 0, 0, 4'd9, 1, 1);
`else
    check_all("sub_as_nop_t1", 8'h00, 0, 0, 0, 4'd0, 1, 1);
`endif
    @(negedge clock);
    check("sub_busy_after", busy, 1'b0);

    // NOP opcode 1xx
    issue(9'b110_011_101);
    check_all("nop_t1", 8'h00, 0, 0, 0, 4'd0, 1, 1);
    @(negedge clock);
    check("nop_busy_after", busy, 1'b0);

    // add R3,R3 (X==Y)
    issue(9'b010_011_011);
    check_all("addxx_t1", 8'h00, 1, 0, 0, 4'd3, 0, 1);
    @(negedge clock);
    check_all("addxx_t2", 8'h00, 0, 1, 0, 4'd3, 0, 1);
    @(negedge clock);
    check_all("addxx_t3", 8'h08, 0, 0, 0, 4'd9, 1, 1);

    // run held high: back-to-back mv then mvi R3
    @(negedge clock);
    run   = 1'b1;
    instr = 9'b000_101_010;
    @(negedge clock);
    check_all("b2b_first_t1", 8'h20, 0, 0, 0, 4'd2, 1, 1);
    instr = 9'b001_011_000;
    @(negedge clock);
    check_all("b2b_t0", 8'h00, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clock);
    run = 1'b0;
    check_all("b2b_second_t1", 8'h08, 0, 0, 0, 4'd8, 1, 1);
    @(negedge clock);

    // reset during T2 of add R1,R3
    issue(9'b010_001_011);
    @(negedge clock);
    check("rst_pre_t2_g_en", g_en, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_all("rst_async_outputs", 8'h00, 0, 0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_hold_rin", rin, 8'h00);
    end
    resetn = 1'b1;
    @(negedge clock);
    check_all("rst_release_idle", 8'h00, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clock);
    check("rst_waits_run", busy, 1'b0);
    issue(9'b001_010_000);
    check_all("rst_then_mvi", 8'h04, 0, 0, 0, 4'd8, 1, 1);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Multi-cycle control unit for the 16-bit processor datapath. Latches an instruction when `run` is pulsed, then sequences the one-hot write enables of the general-purpose `register` instances, the ALU operand register A, the result register G and the shared bus multiplexer select over 1–3 execution cycles. It signals completion with a one-cycle `done` pulse. It sits between the instruction source and the register/ALU datapath and is the only driver of their enables.

## Interface
- `RIDX`, default 3: register index width; NREG = 2**RIDX general-purpose registers.
- `SELW`, default 4: bus select width; must satisfy 2**SELW >= NREG+2.
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `run`  in  1  start request; sampled only in state T0.
- `instr`  in  3+2*RIDX  instruction {op[2:0], X[RIDX-1:0], Y[RIDX-1:0]}; sampled with `run`.
- `rin`  out  NREG  one-hot write enable to register X (or none).
- `a_en`  out  1  load enable of ALU operand register A.
- `g_en`  out  1  load enable of ALU result register G.
- `alu_sub`  out  1  ALU mode: 1 = subtract, 0 = add.
- `bus_sel`  out  SELW  bus source: 0..NREG-1 = register, NREG = din, NREG+1 = G.
- `done`  out  1  one-cycle pulse on the last cycle of an instruction.
- `busy`  out  1  high whenever state != T0.

## Operation
- States T0 (idle), T1, T2, T3. Internal IR (3+2*RIDX bits) captures `instr` when T0 && run.
- All outputs are decoded combinationally from state and IR.
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#din
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 1xx: NOP.
- T0: all enables 0, bus_sel 0. If run=1, latch IR and go to T1; otherwise stay in T0.
- T1:
  - mv: bus_sel=Y, rin[X]=1, done=1; next state T0.
  - mvi: bus_sel=NREG, rin[X]=1, done=1; next state T0.
  - add/sub: bus_sel=X, a_en=1; next state T2.
  - NOP: done=1, no enables; next state T0.
- T2: bus_sel=Y, g_en=1, alu_sub = (op==011); next state T3.
- T3: bus_sel=NREG+1, rin[X]=1, done=1; next state T0.
- `run` outside T0 is ignored. No queuing, no error flag.
- At most one bit of `rin` is set in any cycle. `rin`, `a_en` and `g_en` are never active together.
- X==Y is legal: mv R3,R3 writes R3 with itself, and add R3,R3 doubles R3.

## Timing
- Latency from the run sample edge:
  - mv / mvi / NOP: done in the next cycle (2 cycles including the T0 cycle).
  - add / sub: done 3 cycles later (4 cycles total).
- `run` held high continuously: a new instruction is accepted in the T0 cycle that follows each done. Minimum issue interval is 2 cycles.
- Reset values: state T0, IR 0, `rin` 0, `a_en` 0, `g_en` 0, `alu_sub` 0, `bus_sel` 0, `done` 0, `busy` 0.
- Reset asserted mid-instruction: all outputs go to 0 asynchronously and no further register write occurs. After reset release, the block waits in T0 for `run`.
- The mvi immediate must be valid on the datapath `din` during T1, i.e. the cycle after the run sample.

## Configuration
- `PROC_CTRL_SUB_EN` defined: opcode 011 executes sub as specified above.
- `PROC_CTRL_SUB_EN` undefined: opcode 011 decodes as NOP, and `alu_sub` is tied to 0.

## Structure
- Package `proc_ctrl_pkg` holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - state enum T0..T3;
  - bus select constants SEL_DIN = NREG and SEL_G = NREG+1.
- One sub-module, `onehot_dec` (RIDX → NREG binary-to-one-hot with enable), generates `rin` from IR.X.

## Test plan
- Reset, then run with mvi R2 (001_010_000): T1 has bus_sel=8, rin=8'h04, done=1; busy falls on the next cycle.
- mv R5,R2: T1 has bus_sel=2, rin=8'h20, done=1; exactly 2 cycles total.
- add R1,R3: T1 a_en=1, bus_sel=1; T2 g_en=1, bus_sel=3, alu_sub=0; T3 bus_sel=9, rin=8'h02, done=1.
- sub R0,R0 with the macro on: T2 has alu_sub=1. With the macro off: done in T1 and no enables asserted.
- run pulsed during T2: ignored, and the instruction completes unchanged. run held high: the next instruction is accepted in the T0 cycle after done.
- resetn dropped during T2 of add: all outputs 0 immediately, rin never asserted, state T0 after reset release.
